// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue queue: op codes, field widths, class flags.
package fpu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 23;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned FLG_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_MUL = 2'b10;
  localparam logic [OP_W-1:0] OP_DIV = 2'b11;

  localparam int unsigned FLG_NAN  = 3;
  localparam int unsigned FLG_INF  = 2;
  localparam int unsigned FLG_ZERO = 1;
  localparam int unsigned FLG_DEN  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } iq_state_e;

  // IEEE-754 single class flags; all zero for a normal number
  function automatic logic [FLG_W-1:0] fp_class(input logic [WORD_W-1:0] word);
    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             exp_max;
    logic             exp_min;
    logic             man_zero;
    exp_f    = word[WORD_W-2 -: EXP_W];
    man_f    = word[MAN_W-1:0];
    exp_max  = (exp_f == {EXP_W{1'b1}});
    exp_min  = (exp_f == {EXP_W{1'b0}});
    man_zero = (man_f == {MAN_W{1'b0}});
    fp_class           = '0;
    fp_class[FLG_NAN]  = exp_max && !man_zero;
    fp_class[FLG_INF]  = exp_max &&  man_zero;
    fp_class[FLG_ZERO] = exp_min &&  man_zero;
    fp_class[FLG_DEN]  = exp_min && !man_zero;
  endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO with a combinational head read and modulo-DEPTH pointers.
module fpu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 70
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Callers must not push when full or pop when empty; guard anyway
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage write; contents need no reset since reads are gated by occupancy
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fpu_issue_queue.sv
// In-order, flow-controlled issue stage around a combinational FP arithmetic unit.
module fpu_issue_queue
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W-1:0]       in_a,
  input  logic [WORD_W-1:0]       in_b,
  input  logic [OP_W-1:0]         in_op,
  input  logic [TAG_W-1:0]        in_tag,
  output logic [WORD_W-1:0]       fpu_a,
  output logic [WORD_W-1:0]       fpu_b,
  output logic [OP_W-1:0]         fpu_op,
  input  logic [WORD_W-1:0]       fpu_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W-1:0]       out_result,
  output logic [TAG_W-1:0]        out_tag,
  output logic [FLG_W-1:0]        out_flags,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned ENT_W = 2 * WORD_W + OP_W + TAG_W;

  iq_state_e         r_state;
  logic              r_out_valid;
  logic [WORD_W-1:0] r_out_result;
  logic [TAG_W-1:0]  r_out_tag;
  logic [FLG_W-1:0]  r_out_flags;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [ENT_W-1:0]  w_entry;
  logic [ENT_W-1:0]  w_head;
  logic [WORD_W-1:0] w_head_a;
  logic [WORD_W-1:0] w_head_b;
  logic [OP_W-1:0]   w_head_op;
  logic [TAG_W-1:0]  w_head_tag;

  // No bypass: a full FIFO refuses a push even when it pops in the same cycle
  assign in_ready = !w_full && !rst;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_state == ST_EXEC);
  assign w_entry  = {in_a, in_b, in_op, in_tag};

  fpu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  assign w_head_a   = w_head[ENT_W-1 -: WORD_W];
  assign w_head_b   = w_head[ENT_W-WORD_W-1 -: WORD_W];
  assign w_head_op  = w_head[TAG_W+OP_W-1 -: OP_W];
  assign w_head_tag = w_head[TAG_W-1:0];

  // Present the head entry to the arithmetic unit; quiet zeros when empty
  assign fpu_a  = w_empty ? '0 : w_head_a;
  assign fpu_b  = w_empty ? '0 : w_head_b;
  assign fpu_op = w_empty ? '0 : w_head_op;

  // Sequencer: wait for work, let the unit settle a cycle, then hold the result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
      r_out_flags  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_out_result <= fpu_result;
          r_out_tag    <= w_head_tag;
          r_out_flags  <= fp_class(fpu_result);
          r_out_valid  <= 1'b1;
          r_state      <= ST_HOLD;
        end
        ST_HOLD: begin
          // Registered occupancy: a push in this same cycle is seen only next cycle
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= w_empty ? ST_IDLE : ST_EXEC;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;
  assign out_flags  = r_out_flags;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed bench for fpu_issue_queue with a table-driven stand-in arithmetic unit.
module tb_fpu_issue_queue;
  import fpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_op;
  logic [3:0]  in_tag;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic [3:0]  out_flags;
  logic [2:0]  count;

  int n_cmp;
  int n_fail;

  fpu_issue_queue #(
    .DEPTH (4),
    .TAG_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_op     (fpu_op),
    .fpu_result (fpu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_flags  (out_flags),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in arithmetic unit: exact answers for the operand pairs used below
  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    if      (op == OP_ADD && a == 32'h3F800000 && b == 32'h40000000) fpu_model = 32'h40400000;
    else if (op == OP_ADD && a == 32'h3F800000 && b == 32'h3F800000) fpu_model = 32'h40000000;
    else if (op == OP_ADD && a == 32'h7FC00000 && b == 32'h3F800000) fpu_model = 32'h7FC00000;
    else if (op == OP_SUB && a == 32'h3F800000 && b == 32'h3F800000) fpu_model = 32'h00000000;
    else if (op == OP_MUL && a == 32'h40000000 && b == 32'h40400000) fpu_model = 32'h40C00000;
    else if (op == OP_MUL && a == 32'h00800000 && b == 32'h3F000000) fpu_model = 32'h00400000;
    else if (op == OP_DIV && a == 32'h3F800000 && b == 32'h00000000) fpu_model = 32'h7F800000;
    else fpu_model = 32'hDEADBEEF;
  endfunction

  always_comb fpu_result = fpu_model(fpu_a, fpu_b, fpu_op);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Present one request for a single edge, then drop in_valid
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [3:0] tag);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_tag   = tag;
    step();
    in_valid = 1'b0;
  endtask

  // Request accepted into an empty queue; result appears two edges later, then is taken
  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [3:0] tag,
                         input logic [31:0] exp_res, input logic [3:0] exp_flg);
    out_ready = 1'b1;
    send(a, b, op, tag);
    step();
    chk({name, "_valid_n1"}, 32'(out_valid), 32'd0);
    step();
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_result"}, out_result, exp_res);
    chk({name, "_tag"}, 32'(out_tag), 32'(tag));
    chk({name, "_flags"}, 32'(out_flags), 32'(exp_flg));
    step();
    chk({name, "_taken"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    in_tag    = '0;
    out_ready = 1'b0;

    // Reset state
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_in_ready_low_rst", 32'(in_ready), 32'd1);
    chk("rst_fpu_a_empty", fpu_a, 32'd0);

    // Single add with latency checks
    out_ready = 1'b1;
    send(32'h3F800000, 32'h40000000, OP_ADD, 4'd3);
    chk("add_count", 32'(count), 32'd1);
    chk("add_fpu_a", fpu_a, 32'h3F800000);
    chk("add_fpu_b", fpu_b, 32'h40000000);
    chk("add_valid_n", 32'(out_valid), 32'd0);
    step();
    chk("add_valid_n1", 32'(out_valid), 32'd0);
    step();
    chk("add_valid_n2", 32'(out_valid), 32'd1);
    chk("add_result", out_result, 32'h40400000);
    chk("add_tag", 32'(out_tag), 32'd3);
    chk("add_flags", 32'(out_flags), 32'd0);
    chk("add_count_popped", 32'(count), 32'd0);
    step();
    chk("add_taken", 32'(out_valid), 32'd0);

    // Arithmetic and class-flag vectors
    run_one("mul",  32'h40000000, 32'h40400000, OP_MUL, 4'd5, 32'h40C00000, 4'b0000);
    run_one("div0", 32'h3F800000, 32'h00000000, OP_DIV, 4'd6, 32'h7F800000, 4'b0100);
    run_one("sub0", 32'h3F800000, 32'h3F800000, OP_SUB, 4'd7, 32'h00000000, 4'b0010);
    run_one("nan",  32'h7FC00000, 32'h3F800000, OP_ADD, 4'd8, 32'h7FC00000, 4'b1000);
    run_one("den",  32'h00800000, 32'h3F000000, OP_MUL, 4'd9, 32'h00400000, 4'b0001);

    // Backpressure: five back-to-back pushes while the result is held
    out_ready = 1'b0;
    in_a      = 32'h3F800000;
    in_b      = 32'h3F800000;
    in_op     = OP_ADD;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_tag   = 4'(i);
      step();
    end
    chk("bp_full_count", 32'(count), 32'd4);
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    chk("bp_held_valid", 32'(out_valid), 32'd1);
    chk("bp_held_tag", 32'(out_tag), 32'd0);
    in_tag = 4'd15;
    step();
    step();
    in_valid = 1'b0;
    chk("bp_refused_count", 32'(count), 32'd4);
    chk("bp_stable_result", out_result, 32'h40000000);
    chk("bp_stable_tag", 32'(out_tag), 32'd0);
    chk("bp_stable_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_tag", 32'(out_tag), 32'(k));
      chk("drain_result", out_result, 32'h40000000);
      step();
      chk("drain_gap", 32'(out_valid), 32'd0);
      step();
    end
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_idle", 32'(out_valid), 32'd0);

    // Reset while holding a result with two entries queued
    out_ready = 1'b0;
    in_a      = 32'h3F800000;
    in_b      = 32'h3F800000;
    in_op     = OP_ADD;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_tag = 4'(i + 10);
      step();
    end
    in_valid = 1'b0;
    chk("mrst_pre_valid", 32'(out_valid), 32'd1);
    chk("mrst_pre_count", 32'(count), 32'd2);
    rst = 1'b1;
    #1;
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_result", out_result, 32'd0);
    chk("mrst_tag", 32'(out_tag), 32'd0);
    chk("mrst_flags", 32'(out_flags), 32'd0);
    step();
    chk("mrst_no_output", 32'(out_valid), 32'd0);
    run_one("post_rst", 32'h40000000, 32'h40400000, OP_MUL, 4'hA, 32'h40C00000, 4'b0000);

    // Push during the handshake of the only held result
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, OP_ADD, 4'hB);
    step();
    step();
    chk("hs_held_valid", 32'(out_valid), 32'd1);
    chk("hs_held_tag", 32'(out_tag), 32'd11);
    chk("hs_held_count", 32'(count), 32'd0);
    out_ready = 1'b1;
    send(32'h3F800000, 32'h3F800000, OP_ADD, 4'hC);
    chk("hs_after_valid", 32'(out_valid), 32'd0);
    chk("hs_after_count", 32'(count), 32'd1);
    step();
    chk("hs_exec_valid", 32'(out_valid), 32'd0);
    step();
    chk("hs_new_valid", 32'(out_valid), 32'd1);
    chk("hs_new_tag", 32'(out_tag), 32'd12);
    chk("hs_new_result", out_result, 32'h40000000);
    step();
    chk("hs_done", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
